ahb_bus_arbiter: RTL

- Shares the single AHB-Lite slave path between NM masters built on the in-house AHB master interface (HADDR/HWDATA/HWRITE/HTRANS, HREADY).
- Grants the bus round-robin and re-arbitrates only at transfer boundaries.
- Multiplexes each master's address/control onto the shared bus, and its write data one phase later.
- Sits between the master instances and the slave decoder/memory.

---
 rtl/ahb_bus_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite bus arbiter: round-robin grant among NM masters, re-arbitrated only at
// transfer boundaries. Address/control follow the address-phase owner and write data
// follows the data-phase owner, so a handover never drops an in-flight write.
module ahb_bus_arbiter #(
  parameter int unsigned NM       = 4,  // 2..4, HMASTER is 2 bits wide
  parameter int unsigned MAX_HOLD = 8   // 0 disables the tenure limit
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NM-1:0]    HBUSREQ,
  output logic [NM-1:0]    HGRANT,
  output logic [1:0]       HMASTER,
  input  logic [NM*32-1:0] M_HADDR,
  input  logic [NM*32-1:0] M_HWDATA,
  input  logic [NM-1:0]    M_HWRITE,
  input  logic [NM*2-1:0]  M_HTRANS,
  input  logic             HREADY,
  output logic [31:0]      HADDR,
  output logic [31:0]      HWDATA,
  output logic             HWRITE,
  output logic [1:0]       HTRANS
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CntW-1:0] CntMax = (MAX_HOLD > 0) ? CntW'(MAX_HOLD - 1) : '0;

  typedef enum logic {StPark, StOwn} state_e;

  state_e          state_q;
  logic [NM-1:0]   hgrant_q;
  logic [1:0]      hmaster_q;
  logic [1:0]      data_owner_q;  // data-phase owner, lags hmaster_q by one accepted edge
  logic [CntW-1:0] cnt_q;

  logic [1:0]      cand;
  logic [1:0]      idx;
  logic            found;
  logic            owner_req;
  logic            other_req;

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign owner_req = |(HBUSREQ & hgrant_q);
  assign other_req = |(HBUSREQ & ~hgrant_q);

  // Round-robin search from the slot after the current owner; owner itself is last.
  always_comb begin
    cand  = hmaster_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      idx = 2'((32'(hmaster_q) + k) % NM);
      if (!found && HBUSREQ[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  // Shared bus mux: address/control from the address owner, write data from the data owner.
  always_comb begin
    HADDR  = '0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
    HWDATA = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (hmaster_q == 2'(i)) begin
        HADDR  = M_HADDR[32*i +: 32];
        HWRITE = M_HWRITE[i];
        HTRANS = M_HTRANS[2*i +: 2];
      end
      if (data_owner_q == 2'(i)) begin
        HWDATA = M_HWDATA[32*i +: 32];
      end
    end
  end

  // Arbitration FSM with registered grant, owner, data owner and hold counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StPark;
      hgrant_q     <= NM'(1);
      hmaster_q    <= 2'd0;
      data_owner_q <= 2'd0;
      cnt_q        <= '0;
    end else if (HREADY) begin
      data_owner_q <= hmaster_q;
      unique case (state_q)
        StPark: begin
          if (|HBUSREQ) begin
            state_q   <= StOwn;
            hmaster_q <= cand;
            hgrant_q  <= NM'(1) << cand;
            cnt_q     <= '0;
          end
        end
        StOwn: begin
          if (!owner_req && HTRANS == 2'b00) begin
            cnt_q <= '0;
            if (other_req) begin
              hmaster_q <= cand;
              hgrant_q  <= NM'(1) << cand;
            end else begin
              state_q   <= StPark;
              hmaster_q <= 2'd0;
              hgrant_q  <= NM'(1);
            end
          end else if (owner_req && HTRANS[1] && (MAX_HOLD > 0)) begin
            if (cnt_q == CntMax && other_req) begin
              // Tenure limit reached with a competitor waiting: forced handover.
              hmaster_q <= cand;
              hgrant_q  <= NM'(1) << cand;
              cnt_q     <= '0;
            end else if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StPark;
      endcase
    end
  end

endmodule
